// File: rtl/mcycle_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
package mcycle_pkg;

   // MCycleOp encoding: bit 1 selects divide, bit 0 selects signed.
   typedef enum logic [1:0] {
      OP_MULU = 2'b00,
      OP_MULS = 2'b01,
      OP_DIVU = 2'b10,
      OP_DIVS = 2'b11
   } op_e;

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_e;

endpackage

// File: rtl/mcycle_abs_neg.sv
// Conditional two's-complement: y = neg ? -a : a.
module mcycle_abs_neg #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic         neg,
   output logic [W-1:0] y
);

   // Negate on request; the most negative value maps onto itself, which
   // reads correctly as an unsigned magnitude.
   always_comb begin
      y = neg ? (~a + W'(1)) : a;
   end

endmodule

// File: rtl/mcycle_ext.sv
// Multi-cycle signed/unsigned multiply and restoring divide, one bit per cycle.
module mcycle_ext
   import mcycle_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESETn,
   input  logic             Start,
   input  logic [1:0]       MCycleOp,
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   output logic [WIDTH-1:0] Result1,
   output logic [WIDTH-1:0] Result2,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e             state, state_d;
   op_e                op_q;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc, acc_nxt;
   logic [WIDTH-1:0]   bmag;
   logic               neg_q, neg_r, zero_q;

   logic               sgn1, sgn2, load, finish, is_mul;
   logic [WIDTH-1:0]   mag1, mag2;
   logic [WIDTH:0]     sum, shl, diff;
   logic               ge;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   assign sgn1   = MCycleOp[0] & Operand1[WIDTH-1];
   assign sgn2   = MCycleOp[0] & Operand2[WIDTH-1];
   assign is_mul = (op_q == OP_MULU) || (op_q == OP_MULS);

   mcycle_abs_neg #(.W(WIDTH)) u_abs1 (.a(Operand1), .neg(sgn1), .y(mag1));
   mcycle_abs_neg #(.W(WIDTH)) u_abs2 (.a(Operand2), .neg(sgn2), .y(mag2));

   // Multiply and divide share one accumulator: the low half starts as the
   // multiplier (consumed LSB first) or the dividend (consumed MSB first),
   // so the Operand1 magnitude seeds it in both cases.
   always_comb begin
      sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, bmag} : '0);
      shl  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff = shl - {1'b0, bmag};
      ge   = (shl >= {1'b0, bmag});
      if (is_mul) begin
         acc_nxt = {sum, acc[WIDTH-1:1]};
      end else begin
         acc_nxt = {(ge ? diff[WIDTH-1:0] : shl[WIDTH-1:0]), acc[WIDTH-2:0], ge};
      end
   end

   mcycle_abs_neg #(.W(2*WIDTH)) u_fixp (.a(acc_nxt), .neg(neg_q), .y(prod_fix));
   mcycle_abs_neg #(.W(WIDTH)) u_fixq (.a(acc_nxt[WIDTH-1:0]), .neg(neg_q), .y(quot_fix));
   mcycle_abs_neg #(.W(WIDTH)) u_fixr (.a(acc_nxt[2*WIDTH-1:WIDTH]), .neg(neg_r), .y(rem_fix));

   // Next-state logic: accept Start only when idle, finish on the last iteration.
   always_comb begin
      state_d = state;
      load    = 1'b0;
      finish  = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               load    = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            if (cnt == LAST) begin
               finish  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Datapath registers and result write-back.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         op_q      <= OP_MULU;
         cnt       <= '0;
         acc       <= '0;
         bmag      <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         zero_q    <= 1'b0;
         Result1   <= '0;
         Result2   <= '0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         DivByZero <= 1'b0;
      end else begin
         Done <= 1'b0;
         if (load) begin
            op_q   <= op_e'(MCycleOp);
            cnt    <= '0;
            acc    <= {{WIDTH{1'b0}}, mag1};
            bmag   <= mag2;
            neg_q  <= sgn1 ^ sgn2;
            neg_r  <= sgn1;
            zero_q <= MCycleOp[1] && (Operand2 == '0);
            Busy   <= 1'b1;
         end else if (state == CALC) begin
            acc <= acc_nxt;
            cnt <= cnt + CW'(1);
            if (finish) begin
               // With a zero divisor the remainder rebuilds the dividend
               // magnitude; re-signing it returns Operand1 as latched.
               if (is_mul) begin
                  Result1 <= prod_fix[WIDTH-1:0];
                  Result2 <= prod_fix[2*WIDTH-1:WIDTH];
               end else begin
                  Result1 <= zero_q ? '1 : quot_fix;
                  Result2 <= rem_fix;
               end
               DivByZero <= zero_q;
               Busy      <= 1'b0;
               Done      <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mcycle_ext.sv
// Directed bench for mcycle_ext at WIDTH=32 and WIDTH=8.
module tb_mcycle_ext;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start32, start8;
   logic [1:0]  op;
   logic [31:0] opa, opb;

   logic [31:0] r1_32, r2_32;
   logic        busy32, done32, dbz32;
   logic [7:0]  r1_8, r2_8;
   logic        busy8, done8, dbz8;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   mcycle_ext #(.WIDTH(32)) dut32 (
      .CLK(clk), .RESETn(rst_n), .Start(start32), .MCycleOp(op),
      .Operand1(opa), .Operand2(opb), .Result1(r1_32), .Result2(r2_32),
      .Busy(busy32), .Done(done32), .DivByZero(dbz32)
   );

   mcycle_ext #(.WIDTH(8)) dut8 (
      .CLK(clk), .RESETn(rst_n), .Start(start8), .MCycleOp(op),
      .Operand1(opa[7:0]), .Operand2(opb[7:0]), .Result1(r1_8), .Result2(r2_8),
      .Busy(busy8), .Done(done8), .DivByZero(dbz8)
   );

   typedef struct {
      bit          n;
      logic [1:0]  op;
      logic [31:0] a, b, r1, r2;
      logic        z;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic sample(input bit n, output logic [31:0] r1, output logic [31:0] r2,
                         output logic b, output logic d, output logic z);
      if (n) begin
         r1 = {24'd0, r1_8}; r2 = {24'd0, r2_8}; b = busy8; d = done8; z = dbz8;
      end else begin
         r1 = r1_32; r2 = r2_32; b = busy32; d = done32; z = dbz32;
      end
   endtask

   // One operation with a single-cycle Start; operands are scrambled while busy.
   task automatic do_op(input string nm, input bit n, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er1, input logic [31:0] er2, input logic ez);
      int w, lat, bc;
      logic got;
      logic [31:0] r1, r2;
      logic bs, dn, z;
      w = n ? 8 : 32;
      @(posedge clk); #1;
      op = o; opa = a; opb = b;
      if (n) start8 = 1'b1; else start32 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0; start32 = 1'b0;
      op = 2'($urandom); opa = $urandom; opb = $urandom;
      sample(n, r1, r2, bs, dn, z);
      bc  = bs ? 1 : 0;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         sample(n, r1, r2, bs, dn, z);
         if (dn) got = 1'b1;
         else if (bs) bc++;
      end
      chk({nm, " latency"}, 64'(got ? lat : -1), 64'(w));
      chk({nm, " busy cycles"}, 64'(bc), 64'(w));
      chk({nm, " r1"}, {32'd0, r1}, {32'd0, er1});
      chk({nm, " r2"}, {32'd0, r2}, {32'd0, er2});
      chk({nm, " dbz"}, {63'd0, z}, {63'd0, ez});
      @(posedge clk); #1;
      sample(n, r1, r2, bs, dn, z);
      chk({nm, " done pulse width"}, {63'd0, dn}, 64'd0);
      chk({nm, " r1 held"}, {32'd0, r1}, {32'd0, er1});
   endtask

   task automatic drain();
      int k = 0;
      while ((busy32 || busy8) && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      chk("drain idle", {62'd0, busy32, busy8}, 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int dones, times[$], cyc;

      vecs[0]  = '{0, 2'b00, 32'd6,        32'd3,        32'd18,       32'd0,        1'b0};
      vecs[1]  = '{0, 2'b01, 32'hfcdeffff, 32'hfaffffff, 32'h08210001, 32'h000fa500, 1'b0};
      vecs[2]  = '{0, 2'b11, 32'hfcdefffd, 32'd2,        32'hfe6f7fff, 32'hffffffff, 1'b0};
      vecs[3]  = '{0, 2'b10, 32'hfcdefffd, 32'd2,        32'h7e6f7ffe, 32'd1,        1'b0};
      vecs[4]  = '{0, 2'b10, 32'd7,        32'd0,        32'hffffffff, 32'd7,        1'b1};
      vecs[5]  = '{0, 2'b00, 32'd2,        32'd2,        32'd4,        32'd0,        1'b0};
      vecs[6]  = '{0, 2'b11, 32'h80000000, 32'hffffffff, 32'h80000000, 32'd0,        1'b0};
      vecs[7]  = '{0, 2'b11, 32'hfffffff9, 32'd2,        32'hfffffffd, 32'hffffffff, 1'b0};
      vecs[8]  = '{0, 2'b11, 32'd7,        32'hfffffffe, 32'hfffffffd, 32'd1,        1'b0};
      vecs[9]  = '{0, 2'b11, 32'hfffffff9, 32'd0,        32'hffffffff, 32'hfffffff9, 1'b1};
      vecs[10] = '{0, 2'b00, 32'hffffffff, 32'hffffffff, 32'h00000001, 32'hfffffffe, 1'b0};
      vecs[11] = '{0, 2'b01, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0};
      vecs[12] = '{1, 2'b00, 32'd6,        32'd3,        32'd18,       32'd0,        1'b0};
      vecs[13] = '{1, 2'b01, 32'hff,       32'h02,       32'hfe,       32'hff,       1'b0};
      vecs[14] = '{1, 2'b11, 32'hfd,       32'h02,       32'hff,       32'hff,       1'b0};
      vecs[15] = '{1, 2'b10, 32'hfd,       32'h02,       32'h7e,       32'h01,       1'b0};
      vecs[16] = '{1, 2'b10, 32'd7,        32'd0,        32'hff,       32'd7,        1'b1};
      vecs[17] = '{1, 2'b00, 32'd2,        32'd2,        32'd4,        32'd0,        1'b0};
      vecs[18] = '{1, 2'b11, 32'h80,       32'hff,       32'h80,       32'd0,        1'b0};
      vecs[19] = '{1, 2'b01, 32'h80,       32'h80,       32'h00,       32'h40,       1'b0};

      rst_n = 1'b0; start32 = 1'b0; start8 = 1'b0; op = 2'b00; opa = '0; opb = '0;
      #12;
      chk("reset r1/r2 w32", {r2_32, r1_32}, 64'd0);
      chk("reset flags w32", {61'd0, busy32, done32, dbz32}, 64'd0);
      chk("reset outputs w8", {45'd0, r2_8, r1_8, busy8, done8, dbz8}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].n, vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].r1, vecs[i].r2, vecs[i].z);
      end

      // Held Start: back-to-back operations, one Done every WIDTH+1 cycles.
      @(posedge clk); #1;
      op = 2'b00; opa = 32'd3; opb = 32'd5; start32 = 1'b1;
      cyc = 0;
      for (int k = 0; k < 120; k++) begin
         @(posedge clk); #1;
         cyc++;
         if (done32) times.push_back(cyc);
      end
      start32 = 1'b0;
      chk("held start done count", 64'(times.size()), 64'd3);
      if (times.size() == 3) begin
         chk("held start first done", 64'(times[0]), 64'd33);
         chk("held start period a", 64'(times[1] - times[0]), 64'd33);
         chk("held start period b", 64'(times[2] - times[1]), 64'd33);
      end
      chk("held start r1", {32'd0, r1_32}, 64'd15);
      drain();

      // Start pulse while busy is ignored.
      @(posedge clk); #1;
      op = 2'b00; opa = 32'd7; opb = 32'd9; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      dones = 0;
      for (int k = 0; k < 80; k++) begin
         if (k == 5) begin opa = 32'd100; opb = 32'd100; start32 = 1'b1; end
         if (k == 6) start32 = 1'b0;
         @(posedge clk); #1;
         if (done32) dones++;
      end
      chk("busy start done count", 64'(dones), 64'd1);
      chk("busy start r1", {32'd0, r1_32}, 64'd63);

      // Reset in the middle of an operation after a divide-by-zero result.
      do_op("pre-reset div0", 1'b0, 2'b10, 32'd9, 32'd0, 32'hffffffff, 32'd9, 1'b1);
      @(posedge clk); #1;
      op = 2'b10; opa = 32'd1000; opb = 32'd7; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
      end
      #2 rst_n = 1'b0;
      #1;
      chk("mid reset r1/r2", {r2_32, r1_32}, 64'd0);
      chk("mid reset flags", {61'd0, busy32, done32, dbz32}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         if (done32 || busy32) dones++;
      end
      chk("no done after reset", 64'(dones), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
